fast_command_encoder: RTL

//  Transmit side of the ETROC2 fast-command link. Queues command requests and serializes one 8-bit

---
 rtl/fast_command_encoder.sv | 118 +++++++++++
 1 files changed

// File: rtl/fast_command_encoder.sv
// Fast-command link transmitter: queues command requests and serializes one 8-bit
// symbol per 8-cycle frame, MSB first, filling empty frames with the IDLE symbol.
module fast_command_encoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  IDLE_CODE  = 8'hF0
) (
    input  logic                               clk320,
    input  logic                               reset,
    input  logic                               cmdValid,
    input  logic [3:0]                         cmdSel,
    output logic                               cmdReady,
    input  logic                               alignMode,
    output logic                               fc,
    output logic                               wordStart,
    output logic [9:0]                         txCmd,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifoCount,
    output logic                               invalidCmd
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW       = $clog2(FIFO_DEPTH);
    localparam int unsigned MAX_SEL  = 9;

    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [9:0]    cur_idx;
    logic [3:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          sel_legal;
    logic          push;
    logic          pop;
    logic          frame_end;
    logic [3:0]    head;

    // Symbol table indexed by command number; out-of-range never reaches here.
    function automatic logic [7:0] sel_code(input logic [3:0] sel);
        logic [7:0] code;
        case (sel)
            4'd1:    code = 8'h33;
            4'd2:    code = 8'h5A;
            4'd3:    code = 8'h55;
            4'd4:    code = 8'h66;
            4'd5:    code = 8'h69;
            4'd6:    code = 8'h96;
            4'd7:    code = 8'h99;
            4'd8:    code = 8'hA5;
            4'd9:    code = 8'hAA;
            default: code = IDLE_CODE;
        endcase
        return code;
    endfunction

    assign full      = (fifoCount == CW'(FIFO_DEPTH));
    assign cmdReady  = !full;
    assign sel_legal = (cmdSel <= 4'(MAX_SEL));
    assign push      = cmdValid & cmdReady & sel_legal;
    assign frame_end = (bit_cnt == 3'd7);
    assign pop       = frame_end & !alignMode & (fifoCount != '0);
    assign head      = fifo_mem[rd_ptr];

    assign fc        = shreg[7];
    assign wordStart = (bit_cnt == 3'd0);
    assign txCmd     = cur_idx;

    // Serializer: shift within the frame, load the next symbol on the last bit.
    always_ff @(posedge clk320) begin
        if (reset) begin
            bit_cnt <= 3'd0;
            shreg   <= IDLE_CODE;
            cur_idx <= 10'd1;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (frame_end) begin
                if (pop) begin
                    shreg   <= sel_code(head);
                    cur_idx <= 10'(1) << head;
                end else begin
                    shreg   <= IDLE_CODE;
                    cur_idx <= 10'd1;
                end
            end else begin
                shreg <= {shreg[6:0], 1'b0};
            end
        end
    end

    // Queue bookkeeping; pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk320) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifoCount  <= '0;
            invalidCmd <= 1'b0;
        end else begin
            invalidCmd <= cmdValid & cmdReady & !sel_legal;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + CW'(1);
                2'b01:   fifoCount <= fifoCount - CW'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    always_ff @(posedge clk320) begin
        if (!reset && push) begin
            fifo_mem[wr_ptr] <= cmdSel;
        end
    end

endmodule
